// File: rtl/pipe_hold_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_hold_ctrl.
// master = stage side driving requests, slave = the sequencer.
interface pipe_hold_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  id_stall_req_i;
    logic                  ex_stall_req_i;
    logic                  mem_stall_req_i;
    logic                  jump_req_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  irq_req_i;
    logic [ADDR_WIDTH-1:0] irq_addr_i;
    logic [4:0]            hold_o;
    logic [4:0]            flush_o;
    logic                  pc_load_o;
    logic [ADDR_WIDTH-1:0] pc_load_addr_o;
    logic [1:0]            state_o;
    logic                  timeout_o;

    modport master (
        output id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
        output jump_req_i, jump_addr_i, irq_req_i, irq_addr_i,
        input  hold_o, flush_o, pc_load_o, pc_load_addr_o, state_o, timeout_o
    );

    modport slave (
        input  id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
        input  jump_req_i, jump_addr_i, irq_req_i, irq_addr_i,
        output hold_o, flush_o, pc_load_o, pc_load_addr_o, state_o, timeout_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush sequencer with deferred redirects for the 5-stage core.
// Optional bus-stall watchdog enabled by defining PIPE_HOLD_CTRL_TIMEOUT_EN.
module pipe_hold_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           clk,
    input  logic           rst,
    pipe_hold_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        JPEND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_irq_q, pend_irq_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

    logic [4:0]            hold, flush;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_addr;
    logic                  stall_hi;

    assign stall_hi = bus.mem_stall_req_i | bus.ex_stall_req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pend_valid_q <= 1'b0;
            pend_irq_q   <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_irq_q   <= pend_irq_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_irq_d   = pend_irq_q;
        pend_addr_d  = pend_addr_q;
        hold         = 5'b00000;
        flush        = 5'b00000;
        pc_load      = 1'b0;
        pc_load_addr = '0;

        if (stall_hi) begin
            hold  = bus.mem_stall_req_i ? 5'b01111 : 5'b00111;
            flush = bus.mem_stall_req_i ? 5'b10000 : 5'b01000;
            // A pending irq must survive a later jump; a new irq always wins.
            if (bus.irq_req_i) begin
                pend_valid_d = 1'b1;
                pend_irq_d   = 1'b1;
                pend_addr_d  = bus.irq_addr_i;
            end else if (bus.jump_req_i && !(pend_valid_q && pend_irq_q)) begin
                pend_valid_d = 1'b1;
                pend_irq_d   = 1'b0;
                pend_addr_d  = bus.jump_addr_i;
            end
            state_d = pend_valid_d ? JPEND : STALL;
        end else if (bus.irq_req_i || pend_valid_q || bus.jump_req_i) begin
            pc_load      = 1'b1;
            flush        = 5'b00110;
            pc_load_addr = bus.irq_req_i ? bus.irq_addr_i :
                           pend_valid_q  ? pend_addr_q    : bus.jump_addr_i;
            pend_valid_d = 1'b0;
            pend_irq_d   = 1'b0;
            state_d      = RUN;
        end else if (bus.id_stall_req_i) begin
            hold    = 5'b00011;
            flush   = 5'b00100;
            state_d = STALL;
        end else begin
            state_d = RUN;
        end

        if (rst) begin
            hold         = 5'b00000;
            flush        = 5'b00000;
            pc_load      = 1'b0;
            pc_load_addr = '0;
        end
    end

    assign bus.hold_o         = hold;
    assign bus.flush_o        = flush;
    assign bus.pc_load_o      = pc_load;
    assign bus.pc_load_addr_o = pc_load_addr;
    assign bus.state_o        = rst ? 2'd0 : state_q;

`ifdef PIPE_HOLD_CTRL_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q;
    logic        wd_fire;

    assign wd_fire = bus.mem_stall_req_i && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst || !bus.mem_stall_req_i || wd_fire) begin
            wd_cnt_q <= 16'd0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end

    assign bus.timeout_o = wd_fire && !rst;
`else
    // Constant 0; the comparison only keeps TIMEOUT_CYCLES referenced.
    assign bus.timeout_o = (TIMEOUT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: directed vector table, corner sequences and
// randomized traffic checked against a queue-based redirect model.
module tb_pipe_hold_ctrl;
    localparam int AW = 32;
    localparam int TO = 4;
`ifdef PIPE_HOLD_CTRL_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    pipe_hold_ctrl_if #(.ADDR_WIDTH(AW)) bus();

    pipe_hold_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          rst;
        logic          id;
        logic          ex;
        logic          mem;
        logic          jump;
        logic [AW-1:0] jaddr;
        logic          irq;
        logic [AW-1:0] iaddr;
        logic [4:0]    hold;
        logic [4:0]    flush;
        logic          load;
        logic [AW-1:0] addr;
        logic [1:0]    state;
        logic          to;
    } vec_t;

    typedef struct {
        bit            is_irq;
        logic [AW-1:0] addr;
    } redir_t;

    // Reference model: at most one deferred redirect waits in pend_q.
    redir_t pend_q[$];
    bit     m_stalled;
    int     m_wd;

    logic [4:0]    e_hold, e_flush;
    logic          e_load;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_state;
    logic          e_to;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic id, input logic ex, input logic mem,
                              input logic jump, input logic [AW-1:0] jaddr,
                              input logic irq, input logic [AW-1:0] iaddr);
        redir_t nr;
        e_state = (pend_q.size() != 0) ? 2'd2 : (m_stalled ? 2'd1 : 2'd0);
        e_hold = 0; e_flush = 0; e_load = 0; e_addr = 0; e_to = 0;
        if (r) begin
            e_state = 0;
            pend_q.delete();
            m_stalled = 0;
            m_wd = 0;
            return;
        end
        if (mem || ex) begin
            e_hold  = mem ? 5'b01111 : 5'b00111;
            e_flush = mem ? 5'b10000 : 5'b01000;
            if (irq) begin
                nr.is_irq = 1; nr.addr = iaddr;
                pend_q.delete(); pend_q.push_back(nr);
            end else if (jump && (pend_q.size() == 0 || !pend_q[0].is_irq)) begin
                nr.is_irq = 0; nr.addr = jaddr;
                pend_q.delete(); pend_q.push_back(nr);
            end
            m_stalled = (pend_q.size() == 0);
        end else if (irq || pend_q.size() != 0 || jump) begin
            e_load  = 1;
            e_flush = 5'b00110;
            e_addr  = irq ? iaddr : (pend_q.size() != 0 ? pend_q[0].addr : jaddr);
            pend_q.delete();
            m_stalled = 0;
        end else begin
            if (id) begin
                e_hold = 5'b00011; e_flush = 5'b00100;
            end
            m_stalled = id;
        end
        if (mem) begin
            m_wd++;
            if (m_wd == TO) begin
                e_to = WD_EN;
                m_wd = 0;
            end
        end else begin
            m_wd = 0;
        end
    endtask

    task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                         input logic jump, input logic [AW-1:0] jaddr,
                         input logic irq, input logic [AW-1:0] iaddr);
        @(negedge clk);
        rst = r;
        bus.id_stall_req_i = id;  bus.ex_stall_req_i = ex; bus.mem_stall_req_i = mem;
        bus.jump_req_i = jump;    bus.jump_addr_i = jaddr;
        bus.irq_req_i = irq;      bus.irq_addr_i = iaddr;
        #1;
        model_step(r, id, ex, mem, jump, jaddr, irq, iaddr);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_hold"},  AW'(bus.hold_o),    AW'(e_hold));
        check({tag, "_flush"}, AW'(bus.flush_o),   AW'(e_flush));
        check({tag, "_load"},  AW'(bus.pc_load_o), AW'(e_load));
        check({tag, "_addr"},  bus.pc_load_addr_o, e_addr);
        check({tag, "_state"}, AW'(bus.state_o),   AW'(e_state));
        check({tag, "_to"},    AW'(bus.timeout_o), AW'(e_to));
    endtask

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int loads;
        rst = 1'b1;
        bus.id_stall_req_i = 0; bus.ex_stall_req_i = 0; bus.mem_stall_req_i = 0;
        bus.jump_req_i = 0; bus.jump_addr_i = 0; bus.irq_req_i = 0; bus.irq_addr_i = 0;
        pend_q.delete(); m_stalled = 0; m_wd = 0;

        //             rst id ex mem jmp jaddr     irq iaddr hold      flush     ld addr      st  to
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h100,1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,  2'd0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h100,1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,  2'd0,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,32'h100,1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,  2'd0,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,5'b01111,5'b10000,1'b0,32'h0,  2'd0,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,5'b00111,5'b01000,1'b0,32'h0,  2'd1,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,5'b00111,5'b01000,1'b0,32'h0,  2'd1,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,5'b00011,5'b00100,1'b0,32'h0,  2'd1,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,  2'd1,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h100,1'b0,32'h0,5'b00000,5'b00110,1'b1,32'h100,2'd0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,  2'd0,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h200,1'b0,32'h0,5'b01111,5'b10000,1'b0,32'h0,  2'd0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,5'b01111,5'b10000,1'b0,32'h0,  2'd2,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,5'b01111,5'b10000,1'b0,32'h0,  2'd2,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,5'b01111,5'b10000,1'b0,32'h0,  2'd2,1'b1};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,5'b00000,5'b00110,1'b1,32'h200,2'd2,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,5'b00000,5'b00000,1'b0,32'h0,  2'd0,1'b0};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].id, tbl[i].ex, tbl[i].mem,
                  tbl[i].jump, tbl[i].jaddr, tbl[i].irq, tbl[i].iaddr);
            check($sformatf("t%0d_hold", i),  AW'(bus.hold_o),    AW'(tbl[i].hold));
            check($sformatf("t%0d_flush", i), AW'(bus.flush_o),   AW'(tbl[i].flush));
            check($sformatf("t%0d_load", i),  AW'(bus.pc_load_o), AW'(tbl[i].load));
            check($sformatf("t%0d_addr", i),  bus.pc_load_addr_o, tbl[i].addr);
            check($sformatf("t%0d_state", i), AW'(bus.state_o),   AW'(tbl[i].state));
            check($sformatf("t%0d_to", i),    AW'(bus.timeout_o), AW'(tbl[i].to & WD_EN));
        end

        // Overwrite: irq replaces pending jump, later jump cannot displace irq.
        drive(0, 0, 0, 1, 1, 32'h200, 0, 0);   check_model("ow0");
        drive(0, 0, 0, 1, 0, 0, 1, 32'h8);     check_model("ow1");
        drive(0, 0, 0, 1, 1, 32'h300, 0, 0);   check_model("ow2");
        drive(0, 0, 0, 0, 0, 0, 0, 0);         check_model("ow3");
        check("ow_release_load", AW'(bus.pc_load_o), AW'(1));
        check("ow_release_addr", bus.pc_load_addr_o, 32'h8);
        loads = 0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            check_model($sformatf("ow_after%0d", k));
            loads += int'(bus.pc_load_o);
        end
        check("ow_extra_loads", AW'(loads), AW'(0));

        // Reset while a redirect is pending discards it.
        drive(0, 0, 1, 0, 1, 32'h400, 0, 0);   check_model("rp0");
        drive(1, 0, 0, 0, 0, 0, 0, 0);         check_model("rp1");
        drive(0, 0, 0, 0, 0, 0, 0, 0);         check_model("rp2");
        check("rp_no_load", AW'(bus.pc_load_o), AW'(0));
        check("rp_state", AW'(bus.state_o), AW'(0));

        // Watchdog: nine consecutive mem-stall cycles.
        for (int k = 1; k <= 9; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            check($sformatf("wd_cycle%0d", k), AW'(bus.timeout_o),
                  AW'(WD_EN && (k == 4 || k == 8)));
            check_model($sformatf("wd%0d", k));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);         check_model("wd_end");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 15, AW'($urandom),
                  $urandom_range(0, 99) < 8,  AW'($urandom));
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
